// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin req/ack arbiter.
// The wrap helper keeps rotate/unrotate arithmetic correct for non-power-of-two N.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  function automatic int ptr_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  // Hold counter only has to reach TIMEOUT-1; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0, take the
// lowest set bit, then map that offset back to an absolute requester index.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic         found;

  always_comb begin
    rot   = '0;
    off   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[W'(wrap_add(int'(ptr), j, N))];
    end
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = W'(j);
      end
    end
    valid = found;
    idx   = W'(wrap_add(int'(ptr), int'(off), N));
  end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack channel among N_REQ requesters,
// with an optional forced release when an owner holds ack for TIMEOUT cycles.
module rr_handshake_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int W  = ptr_width(N_REQ);
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  arb_state_e     state;
  logic [W-1:0]   ptr;
  logic [CW-1:0]  cnt;
  logic           pick_valid;
  logic [W-1:0]   pick_idx;
  logic [W-1:0]   ptr_next;

  rr_pick #(
    .N (N_REQ),
    .W (W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ptr_next = (gnt_id == W'(N_REQ - 1)) ? '0 : gnt_id + W'(1);

  // Handshake: requester raises req[i] and holds it; ack[i] rises one clock after
  // req is seen in IDLE; requester drops req[i]; ack[i] falls on the next clock;
  // the channel returns to IDLE only once req[gnt_id] is seen low (return-to-zero).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack         <= '0;
      gnt_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            ack    <= N_REQ'(1) << pick_idx;
            gnt_id <= pick_idx;
            busy   <= 1'b1;
            cnt    <= '0;
            state  <= ACK;
          end
        end
        ACK: begin
          // A req drop on the timeout cycle wins: it is an ordinary release.
          if (!req[gnt_id]) begin
            ack   <= '0;
            state <= RELEASE;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            ack         <= '0;
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (!req[gnt_id]) begin
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack))
    else $error("ack not onehot0: %b", ack);

  a_owner_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (ack == '0) || ack[gnt_id])
    else $error("ack %b not owned by gnt_id %0d", ack, gnt_id);

  a_err_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    timeout_err |=> !timeout_err)
    else $error("timeout_err held longer than one cycle");

  for (genvar i = 0; i < N_REQ; i++) begin : g_rtz
    a_ack_follows_req: assert property (@(posedge clk) disable iff (!rst_n)
      ack[i] && $fell(req[i]) |=> $fell(ack[i]))
      else $error("ack[%0d] did not drop after req fell", i);
  end
`endif

endmodule
